complex_frequency_estimator: RTL and testbench

Measures the frequency of a single complex tone on a streaming I/Q input and reports it as a 32-bit phase-increment word. The word uses the same scale as the NCO frequency input: 2^32 equals one full turn per sample. The block is the receive-side counterpart of the NCO. It closes loops in self-test, for example feeding the NCO output back in and checking the measured word against the programmed word, and it also supports carrier-offset measurement on received streams.

---
 rtl/complex_frequency_estimator.sv | 147 ++++++++++++++
 tb/tb_complex_frequency_estimator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_frequency_estimator.sv
// Streaming I/Q tone frequency estimator: CORDIC phase, differencer, block average.
// Output word uses the NCO scale, 2^32 = one full turn per sample.
module complex_frequency_estimator #(
    parameter int WIDTH    = 16,
    parameter int STAGES   = 16,
    parameter int LOG2_AVG = 10
) (
    input  logic             ipClk,
    input  logic             ipReset,
    input  logic             ipValid,
    input  logic [WIDTH-1:0] ipI,
    input  logic [WIDTH-1:0] ipQ,
    output logic [31:0]      opFrequency,
    output logic             opValid
);

    localparam int XW = WIDTH + 2;
    localparam int SW = 32 + LOG2_AVG;

    // atan(2^-k) with 2^32 = 2*pi, rounded to nearest
    function automatic logic [31:0] atanWord(input int k);
        case (k)
            0:       atanWord = 32'h2000_0000;
            1:       atanWord = 32'h12E4_051E;
            2:       atanWord = 32'h09FB_385B;
            3:       atanWord = 32'h0511_11D4;
            4:       atanWord = 32'h028B_0D43;
            5:       atanWord = 32'h0145_D7E1;
            6:       atanWord = 32'h00A2_F61E;
            7:       atanWord = 32'h0051_7C55;
            8:       atanWord = 32'h0028_BE53;
            9:       atanWord = 32'h0014_5F2F;
            10:      atanWord = 32'h000A_2F98;
            11:      atanWord = 32'h0005_17CC;
            12:      atanWord = 32'h0002_8BE6;
            13:      atanWord = 32'h0001_45F3;
            14:      atanWord = 32'h0000_A2FA;
            15:      atanWord = 32'h0000_517D;
            default: atanWord = 32'h0000_0000;
        endcase
    endfunction

    typedef enum logic {PRIME, ACCUM} stateT;

    logic signed [XW-1:0] xs [0:STAGES];
    logic signed [XW-1:0] ys [0:STAGES];
    logic [31:0]          zs [0:STAGES];
    logic                 vs [0:STAGES];
    logic                 zeroS [0:STAGES];

    logic signed [XW-1:0] iExt, qExt;
    logic [31:0]          phase, prevPhase, d;
    logic                 phaseValid, dValid, diffEn;
    logic signed [SW-1:0] sum, dExt, total;
    logic [LOG2_AVG-1:0]  count;
    stateT                state, stateNext;

    assign iExt = {{2{ipI[WIDTH-1]}}, ipI};
    assign qExt = {{2{ipQ[WIDTH-1]}}, ipQ};

    always_ff @(posedge ipClk) begin
        vs[0]    <= ipReset ? 1'b0 : ipValid;
        zeroS[0] <= (ipI == '0) && (ipQ == '0);
        if (!ipI[WIDTH-1]) begin
            xs[0] <= iExt;
            ys[0] <= qExt;
            zs[0] <= 32'h0000_0000;
        end else if (!ipQ[WIDTH-1]) begin
            xs[0] <= qExt;
            ys[0] <= -iExt;
            zs[0] <= 32'h4000_0000;
        end else begin
            xs[0] <= -qExt;
            ys[0] <= iExt;
            zs[0] <= 32'hC000_0000;
        end
        for (int k = 0; k < STAGES; k++) begin
            vs[k+1]    <= ipReset ? 1'b0 : vs[k];
            zeroS[k+1] <= zeroS[k];
            if (!ys[k][XW-1]) begin
                xs[k+1] <= xs[k] + (ys[k] >>> k);
                ys[k+1] <= ys[k] - (xs[k] >>> k);
                zs[k+1] <= zs[k] + atanWord(k);
            end else begin
                xs[k+1] <= xs[k] - (ys[k] >>> k);
                ys[k+1] <= ys[k] + (xs[k] >>> k);
                zs[k+1] <= zs[k] - atanWord(k);
            end
        end
    end

    // A zero vector has no angle; report 0 instead of the summed atans
    assign phase      = zeroS[STAGES] ? 32'h0 : zs[STAGES];
    assign phaseValid = vs[STAGES];

    always_ff @(posedge ipClk) begin
        if (ipReset) state <= PRIME;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        diffEn    = 1'b0;
        unique case (state)
            PRIME: if (phaseValid) stateNext = ACCUM;
            ACCUM: diffEn = phaseValid;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            prevPhase <= '0;
            dValid    <= 1'b0;
            d         <= '0;
        end else begin
            dValid <= diffEn;
            d      <= phase - prevPhase;
            if (phaseValid) prevPhase <= phase;
        end
    end

    assign dExt  = {{LOG2_AVG{d[31]}}, d};
    assign total = sum + dExt;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            sum         <= '0;
            count       <= '0;
            opFrequency <= '0;
            opValid     <= 1'b0;
        end else begin
            opValid <= 1'b0;
            if (dValid) begin
                if (count == '1) begin
                    opFrequency <= total[LOG2_AVG +: 32];
                    opValid     <= 1'b1;
                    sum         <= '0;
                    count       <= '0;
                end else begin
                    sum   <= total;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_frequency_estimator.sv
// Directed bench for complex_frequency_estimator: NCO-style tones in,
// estimated phase-increment words checked against the programmed word.
module tb_complex_frequency_estimator;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b0;
    logic        ipValid = 1'b0;
    logic [15:0] ipI = '0;
    logic [15:0] ipQ = '0;
    logic [31:0] opFrequency;
    logic        opValid;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int holdErrs = 0;
    logic rstAtEdge = 1'b0;
    logic [31:0] prevFreq;

    int          pulseCyc[$];
    logic [31:0] pulseVal[$];
    int          acceptQ[$];

    localparam int LAT = 18; // edges from accepting edge to output register edge

    complex_frequency_estimator dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .ipValid(ipValid),
        .ipI(ipI),
        .ipQ(ipQ),
        .opFrequency(opFrequency),
        .opValid(opValid)
    );

    always #5 ipClk = ~ipClk;

    always @(posedge ipClk) begin
        cyc       <= cyc + 1;
        rstAtEdge <= ipReset;
    end

    always @(negedge ipClk) begin
        if (opValid === 1'b1) begin
            pulseCyc.push_back(cyc);
            pulseVal.push_back(opFrequency);
        end
        if (!rstAtEdge && opValid !== 1'b1 && opFrequency !== prevFreq)
            holdErrs++;
        prevFreq = opFrequency;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic [15:0] i, input logic [15:0] q);
        ipValid = v;
        ipI = i;
        ipQ = q;
        @(posedge ipClk);
        #1;
        if (v) acceptQ.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0);
    endtask

    task automatic clearLogs();
        pulseCyc.delete();
        pulseVal.delete();
        acceptQ.delete();
    endtask

    task automatic doReset();
        ipReset = 1'b1;
        step(1'b0, 16'h0, 16'h0);
        ipReset = 1'b0;
        clearLogs();
    endtask

    task automatic feed(input logic [31:0] word, input bit negQ, input int period,
                        input int nValid, input bit useConst, input int ci, input int cq);
        logic [31:0] ph = '0;
        real ang;
        int iv, qv;
        for (int n = 0; n < nValid; n++) begin
            if (useConst) begin
                iv = ci;
                qv = cq;
            end else begin
                ang = 6.283185307179586 * real'(ph) / 4294967296.0;
                iv = $rtoi(29490.0 * $cos(ang));
                qv = $rtoi(29490.0 * $sin(ang));
                if (negQ) qv = -qv;
            end
            step(1'b1, 16'(iv), 16'(qv));
            ph += word;
            for (int g = 1; g < period; g++) step(1'b0, 16'(iv), 16'(qv));
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        ipReset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ipValid = 1'b1;
            ipI = 16'($urandom);
            ipQ = 16'($urandom);
            @(posedge ipClk);
            #1;
            nChecks++;
            if (opValid !== 1'b0)
                $display("FAIL reset_opValid: got %b expected 0", opValid);
            if (opValid !== 1'b0) nFails++;
            nChecks++;
            if (opFrequency !== 32'h0) begin
                $display("FAIL reset_opFrequency: got %h expected 0", opFrequency);
                nFails++;
            end
        end
        ipReset = 1'b0;
        for (int k = 0; k < 1043; k++) begin
            step(1'b0, 16'($urandom), 16'($urandom));
            if (opValid !== 1'b0 || opFrequency !== 32'h0) bad++;
        end
        nChecks++;
        if (bad != 0) begin
            $display("FAIL reset_idle_hold: %0d bad cycles, expected 0", bad);
            nFails++;
        end
        clearLogs();
    endtask

    task automatic test_positive_tone();
        longint got;
        doReset();
        feed(32'd85899, 1'b0, 1, 2049, 1'b0, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 2) begin
            $display("FAIL pos_pulse_count: got %0d expected 2", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            nChecks++;
            if (pulseCyc[0] != acceptQ[1024] + LAT) begin
                $display("FAIL pos_first_latency: got edge %0d expected %0d",
                         pulseCyc[0], acceptQ[1024] + LAT);
                nFails++;
            end
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < 85899 - 64 || got > 85899 + 64) begin
                $display("FAIL pos_value0: got %0d expected 85899+-64", got);
                nFails++;
            end
        end
        if (pulseCyc.size() >= 2) begin
            nChecks++;
            if (pulseCyc[1] != acceptQ[2048] + LAT) begin
                $display("FAIL pos_second_latency: got edge %0d expected %0d",
                         pulseCyc[1], acceptQ[2048] + LAT);
                nFails++;
            end
            got = longint'($signed(pulseVal[1]));
            nChecks++;
            if (got < 85899 - 64 || got > 85899 + 64) begin
                $display("FAIL pos_value1: got %0d expected 85899+-64", got);
                nFails++;
            end
        end
    endtask

    task automatic test_negative_tone();
        longint got;
        doReset();
        feed(32'd85899, 1'b1, 1, 1025, 1'b0, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL neg_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < -85899 - 64 || got > -85899 + 64) begin
                $display("FAIL neg_value: got %0d expected -85899+-64", got);
                nFails++;
            end
        end
    endtask

    task automatic test_wrap();
        longint got;
        doReset();
        feed(32'h7000_0000, 1'b0, 1, 1025, 1'b0, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL wrap_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < 1879048192 - 64 || got > 1879048192 + 64) begin
                $display("FAIL wrap_value: got %0d expected 1879048192+-64", got);
                nFails++;
            end
        end
    endtask

    task automatic test_gapped();
        longint got;
        doReset();
        feed(32'd85899, 1'b0, 3, 1025, 1'b0, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL gap_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            nChecks++;
            if (pulseCyc[0] != acceptQ[1024] + LAT) begin
                $display("FAIL gap_latency: got edge %0d expected %0d",
                         pulseCyc[0], acceptQ[1024] + LAT);
                nFails++;
            end
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < 85899 - 64 || got > 85899 + 64) begin
                $display("FAIL gap_value: got %0d expected 85899+-64", got);
                nFails++;
            end
        end
    endtask

    task automatic test_reset_mid_block();
        longint got;
        int bad = 0;
        doReset();
        feed(32'd85899, 1'b0, 1, 1524, 1'b0, 0, 0);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL mid_pre_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        ipReset = 1'b1;
        step(1'b1, 16'd20000, 16'd3000);
        ipReset = 1'b0;
        clearLogs();
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 16'h0, 16'h0);
            if (opFrequency !== 32'h0) bad++;
        end
        nChecks++;
        if (bad != 0 || pulseCyc.size() != 0) begin
            $display("FAIL mid_after_reset: %0d nonzero cycles, %0d pulses, expected 0 and 0",
                     bad, pulseCyc.size());
            nFails++;
        end
        feed(32'd85899, 1'b0, 1, 1025, 1'b0, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL mid_post_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            nChecks++;
            if (pulseCyc[0] != acceptQ[1024] + LAT) begin
                $display("FAIL mid_post_latency: got edge %0d expected %0d",
                         pulseCyc[0], acceptQ[1024] + LAT);
                nFails++;
            end
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < 85899 - 64 || got > 85899 + 64) begin
                $display("FAIL mid_post_value: got %0d expected 85899+-64", got);
                nFails++;
            end
        end
    endtask

    task automatic test_zero_dc();
        longint got;
        doReset();
        feed(32'd0, 1'b0, 1, 1025, 1'b1, 0, 0);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1 || pulseVal[0] !== 32'h0) begin
            $display("FAIL zero_input: %0d pulses value %h, expected 1 pulse value 0",
                     pulseCyc.size(), (pulseVal.size() > 0) ? pulseVal[0] : 32'hx);
            nFails++;
        end
        doReset();
        feed(32'd0, 1'b0, 1, 1025, 1'b1, 1000, 1000);
        idle(25);
        nChecks++;
        if (pulseCyc.size() != 1) begin
            $display("FAIL dc_pulse_count: got %0d expected 1", pulseCyc.size());
            nFails++;
        end
        if (pulseCyc.size() >= 1) begin
            got = longint'($signed(pulseVal[0]));
            nChecks++;
            if (got < -1 || got > 1) begin
                $display("FAIL dc_value: got %0d expected 0+-1", got);
                nFails++;
            end
        end
    endtask

    task automatic test_hold();
        nChecks++;
        if (holdErrs != 0) begin
            $display("FAIL output_hold: %0d changes without opValid, expected 0", holdErrs);
            nFails++;
        end
    endtask

    initial begin
        test_reset();
        test_positive_tone();
        test_negative_tone();
        test_wrap();
        test_gapped();
        test_reset_mid_block();
        test_zero_dc();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
